// File: rtl/banked_data_mem.sv
// Byte-banked data memory with unaligned big-endian CPU access and a background
// snapshot engine that fills a tear-free register from idle bank cycles.
module banked_data_mem #(
    parameter int  LANES       = 4,
    parameter int  DEPTH_WORDS = 1024,
    parameter int  ADDR_W      = 32,
    parameter int  SNAP_BYTES  = 32,
    localparam int DATA_W      = 8 * LANES
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_store,
    input  logic [1:0]              req_size,
    input  logic                    req_signed,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [DATA_W-1:0]       req_wdata,
    output logic                    rsp_valid,
    output logic [DATA_W-1:0]       rsp_rdata,
    output logic                    rsp_err,
    input  logic                    snap_start,
    output logic                    snap_busy,
    output logic                    snap_done,
    output logic [8*SNAP_BYTES-1:0] snap_bytes
);
    localparam int LOG_L     = $clog2(LANES);
    localparam int ROW_W     = $clog2(DEPTH_WORDS);
    localparam int SNAP_ROWS = SNAP_BYTES / LANES;
    localparam int RC_W      = $clog2(SNAP_ROWS + 1);

    typedef enum logic { S_IDLE, S_SCAN } snap_state_t;

    logic                    acc;
    logic                    req_err;
    logic                    scan_issue;
    logic [31:0]             req_n;
    logic [ADDR_W:0]         end_addr;
    logic [LOG_L-1:0]        req_lo;
    logic [ROW_W-1:0]        req_row;
    logic [LANES-1:0]        lane_we;
    logic [LANES-1:0]        lane_sel;
    logic [LOG_L-1:0]        lane_d     [LANES];
    logic [ROW_W-1:0]        lane_row   [LANES];
    logic [7:0]              lane_wdata [LANES];
    logic [DATA_W-1:0]       rd_vec;

    logic                    rsp_store_q;
    logic                    rsp_signed_q;
    logic [1:0]              rsp_size_q;
    logic [LOG_L-1:0]        rsp_lo_q;
    logic [31:0]             rsp_n;
    logic [LOG_L-1:0]        rd_lane;
    logic [DATA_W-1:0]       field;
    logic [DATA_W-1:0]       fill_mask;

    snap_state_t             state;
    logic [RC_W-1:0]         rc;
    logic [RC_W-1:0]         cap_row;
    logic                    cap_pending;
    logic [8*SNAP_BYTES-1:0] shadow;
    logic [8*SNAP_BYTES-1:0] shadow_next;

    assign acc        = req_valid & req_ready;
    assign scan_issue = (state == S_SCAN) && !acc && (rc < RC_W'(SNAP_ROWS));
    assign req_n      = 32'd1 << req_size;
    assign end_addr   = {1'b0, req_addr} + (ADDR_W+1)'(req_n) - (ADDR_W+1)'(1);
    assign req_err    = (req_n > 32'(LANES)) || ((end_addr >> LOG_L) >= (ADDR_W+1)'(DEPTH_WORDS));
    assign req_lo     = req_addr[LOG_L-1:0];
    assign req_row    = req_addr[LOG_L +: ROW_W];

    // Lanes below the start lane hold the wrapped tail of the access, one row further on.
    always_comb begin
        lane_we  = '0;
        lane_sel = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_d[l]     = LOG_L'(l) - req_lo;
            lane_sel[l]   = 32'(lane_d[l]) < req_n;
            lane_we[l]    = acc && req_store && !req_err && lane_sel[l];
            lane_row[l]   = scan_issue ? ROW_W'(rc) : req_row + ROW_W'(LOG_L'(l) < req_lo);
            lane_wdata[l] = 8'(req_wdata >> (8 * (req_n - 32'(lane_d[l]) - 32'd1)));
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_bank
        logic [7:0] ram [DEPTH_WORDS];
        logic [7:0] rd_q;

        always_ff @(posedge clk) begin
            if (lane_we[g])
                ram[lane_row[g]] <= lane_wdata[g];
            rd_q <= ram[lane_row[g]];
        end

        assign rd_vec[8*g +: 8] = rd_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_err      <= 1'b0;
            rsp_store_q  <= 1'b0;
            rsp_signed_q <= 1'b0;
            rsp_size_q   <= 2'd0;
            rsp_lo_q     <= '0;
        end else begin
            req_ready <= 1'b1;
            rsp_valid <= acc;
            rsp_err   <= acc && req_err;
            if (acc) begin
                rsp_store_q  <= req_store;
                rsp_signed_q <= req_signed;
                rsp_size_q   <= req_size;
                rsp_lo_q     <= req_lo;
            end
        end
    end

    // Field byte i comes from lane (lo+i) and lands i bytes below the field's top byte.
    always_comb begin
        field     = '0;
        fill_mask = '0;
        rd_lane   = '0;
        rsp_rdata = '0;
        rsp_n     = 32'd1 << rsp_size_q;
        if (rsp_valid && !rsp_store_q && !rsp_err) begin
            for (int i = 0; i < LANES; i++) begin
                if (32'(i) < rsp_n) begin
                    rd_lane = rsp_lo_q + LOG_L'(i);
                    field[8*(int'(rsp_n)-1-i) +: 8] = rd_vec[8*int'(rd_lane) +: 8];
                end
            end
            fill_mask = ~({DATA_W{1'b1}} >> (DATA_W - 8*int'(rsp_n)));
            rsp_rdata = (rsp_signed_q && field[8*int'(rsp_n)-1]) ? (field | fill_mask) : field;
        end
    end

    always_comb begin
        shadow_next = shadow;
        for (int l = 0; l < LANES; l++)
            shadow_next[8*(SNAP_BYTES-1-(int'(cap_row)*LANES+l)) +: 8] = rd_vec[8*l +: 8];
    end

    // The last row is merged straight into snap_bytes so the publish costs no extra cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            rc          <= '0;
            cap_row     <= '0;
            cap_pending <= 1'b0;
            shadow      <= '0;
            snap_bytes  <= '0;
            snap_busy   <= 1'b0;
            snap_done   <= 1'b0;
        end else begin
            snap_done   <= 1'b0;
            cap_pending <= scan_issue;
            if (scan_issue) begin
                cap_row <= rc;
                rc      <= rc + 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (snap_start) begin
                        state     <= S_SCAN;
                        rc        <= '0;
                        snap_busy <= 1'b1;
                    end
                end
                S_SCAN: begin
                    if (cap_pending) begin
                        shadow <= shadow_next;
                        if (cap_row == RC_W'(SNAP_ROWS - 1)) begin
                            snap_bytes <= shadow_next;
                            snap_done  <= 1'b1;
                            snap_busy  <= 1'b0;
                            state      <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_banked_data_mem.sv
// Self-checking bench for banked_data_mem: byte-array memory model plus a response
// scoreboard, with directed snapshot scenarios.
module tb_banked_data_mem;
    localparam int LANES       = 4;
    localparam int DEPTH_WORDS = 1024;
    localparam int ADDR_W      = 32;
    localparam int SNAP_BYTES  = 32;
    localparam int DATA_W      = 8 * LANES;
    localparam int SNAP_ROWS   = SNAP_BYTES / LANES;
    localparam int MEM_BYTES   = LANES * DEPTH_WORDS;

    logic                    clk = 1'b0;
    logic                    resetn = 1'b0;
    logic                    req_valid = 1'b0;
    logic                    req_ready;
    logic                    req_store = 1'b0;
    logic [1:0]              req_size = 2'd0;
    logic                    req_signed = 1'b0;
    logic [ADDR_W-1:0]       req_addr = '0;
    logic [DATA_W-1:0]       req_wdata = '0;
    logic                    rsp_valid;
    logic [DATA_W-1:0]       rsp_rdata;
    logic                    rsp_err;
    logic                    snap_start = 1'b0;
    logic                    snap_busy;
    logic                    snap_done;
    logic [8*SNAP_BYTES-1:0] snap_bytes;

    typedef struct {
        logic [DATA_W-1:0] rdata;
        logic              err;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mem_model  [MEM_BYTES];
    logic [7:0] snap_model [SNAP_BYTES];
    int         errors = 0;
    int         checks = 0;

    banked_data_mem #(
        .LANES(LANES), .DEPTH_WORDS(DEPTH_WORDS), .ADDR_W(ADDR_W), .SNAP_BYTES(SNAP_BYTES)
    ) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .snap_start(snap_start), .snap_busy(snap_busy),
        .snap_done(snap_done), .snap_bytes(snap_bytes)
    );

    always #5 clk = ~clk;

    // Reference behaviour: big-endian byte walk over a flat byte array.
    function automatic void model_op(input logic st, input logic [1:0] sz, input logic sg,
                                     input logic [31:0] a, input logic [31:0] wd,
                                     output logic [31:0] rd, output logic er);
        int          n;
        logic [31:0] f;
        n  = 1 << sz;
        er = (n > LANES) || (((longint'(a) + n - 1) / LANES) >= DEPTH_WORDS);
        rd = '0;
        if (!er) begin
            if (st) begin
                for (int i = 0; i < n; i++)
                    mem_model[int'(a) + i] = wd[8*(n-1-i) +: 8];
            end else begin
                f = '0;
                for (int i = 0; i < n; i++)
                    f = (f << 8) | {24'd0, mem_model[int'(a) + i]};
                if (sg && f[8*n-1] && n < 4)
                    f = f | ~((32'd1 << (8*n)) - 32'd1);
                rd = f;
            end
        end
    endfunction

    function automatic logic [8*SNAP_BYTES-1:0] pack_snap();
        logic [8*SNAP_BYTES-1:0] v;
        v = '0;
        for (int k = 0; k < SNAP_BYTES; k++)
            v[8*(SNAP_BYTES-1-k) +: 8] = snap_model[k];
        return v;
    endfunction

    task automatic copy_snap_model();
        for (int k = 0; k < SNAP_BYTES; k++)
            snap_model[k] = mem_model[k];
    endtask

    task automatic cpu_op(input logic st, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        @(negedge clk);
        model_op(st, sz, sg, a, wd, e.rdata, e.err);
        sb.push_back(e);
        req_valid  = 1'b1;
        req_store  = st;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
    endtask

    task automatic cpu_idle();
        @(negedge clk);
        req_valid = 1'b0;
        req_store = 1'b0;
    endtask

    task automatic wait_snap_done(output int cycles);
        cycles = 0;
        while (snap_done !== 1'b1 && cycles < 60) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    // Scoreboard: every response is matched against the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (resetn && rsp_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL rsp_unexpected: got rdata=%h err=%b, required no response",
                         rsp_rdata, rsp_err);
            end else begin
                e = sb.pop_front();
                if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
                    errors++;
                    $display("[TB] FAIL rsp: got rdata=%h err=%b, required rdata=%h err=%b",
                             rsp_rdata, rsp_err, e.rdata, e.err);
                end
            end
        end
    end

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== '0) begin
            errors++;
            $display("[TB] FAIL reset_port: got ready=%b valid=%b err=%b rdata=%h, required 0 0 0 0",
                     req_ready, rsp_valid, rsp_err, rsp_rdata);
        end
        checks++;
        if (snap_busy !== 1'b0 || snap_done !== 1'b0 || snap_bytes !== '0) begin
            errors++;
            $display("[TB] FAIL reset_snap: got busy=%b done=%b bytes=%h, required zeros",
                     snap_busy, snap_done, snap_bytes);
        end
        resetn = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ready_before_edge: got %b, required 0", req_ready);
        end
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ready_after_edge: got %b, required 1", req_ready);
        end
    endtask

    task automatic test_fill();
        for (int w = 0; w < SNAP_BYTES / 4; w++)
            cpu_op(1'b1, 2'd2, 1'b0, 32'(4*w), $urandom);
        cpu_idle();
    endtask

    task automatic test_load_store();
        cpu_op(1'b1, 2'd2, 1'b0, 32'd0, 32'h11223344);
        cpu_op(1'b0, 2'd2, 1'b0, 32'd0, 32'd0);
        cpu_op(1'b0, 2'd0, 1'b1, 32'd1, 32'd0);
        cpu_op(1'b0, 2'd1, 1'b0, 32'd2, 32'd0);
        cpu_idle();
    endtask

    task automatic test_unaligned();
        cpu_op(1'b1, 2'd1, 1'b0, 32'd3, 32'h000080FF);
        cpu_op(1'b0, 2'd1, 1'b1, 32'd3, 32'd0);
        cpu_op(1'b0, 2'd1, 1'b0, 32'd3, 32'd0);
        cpu_op(1'b0, 2'd0, 1'b0, 32'd2, 32'd0);
        cpu_op(1'b0, 2'd0, 1'b1, 32'd5, 32'd0);
        cpu_op(1'b0, 2'd2, 1'b0, 32'd1, 32'd0);
        cpu_op(1'b0, 2'd2, 1'b1, 32'd3, 32'd0);
        cpu_op(1'b1, 2'd2, 1'b0, 32'd6, 32'hC0DEFACE);
        cpu_op(1'b0, 2'd2, 1'b0, 32'd6, 32'd0);
        cpu_op(1'b0, 2'd0, 1'b1, 32'd7, 32'd0);
        cpu_idle();
    endtask

    task automatic test_errors();
        cpu_op(1'b1, 2'd2, 1'b0, 32'(MEM_BYTES-4), 32'hA1B2C3D4);
        cpu_op(1'b1, 2'd2, 1'b0, 32'(MEM_BYTES-2), 32'hDEADBEEF);
        cpu_op(1'b0, 2'd2, 1'b0, 32'(MEM_BYTES-4), 32'd0);
        cpu_op(1'b0, 2'd2, 1'b0, 32'(MEM_BYTES-2), 32'd0);
        cpu_op(1'b0, 2'd1, 1'b1, 32'(MEM_BYTES-2), 32'd0);
        cpu_op(1'b1, 2'd3, 1'b0, 32'd8, 32'hCAFEF00D);
        cpu_op(1'b0, 2'd2, 1'b0, 32'd8, 32'd0);
        cpu_op(1'b0, 2'd3, 1'b1, 32'd0, 32'd0);
        cpu_op(1'b0, 2'd0, 1'b0, 32'(MEM_BYTES), 32'd0);
        cpu_idle();
    endtask

    task automatic test_back_to_back();
        int sz, n, a;
        cpu_op(1'b1, 2'd2, 1'b0, 32'd12, 32'h5A5AA5A5);
        cpu_op(1'b0, 2'd2, 1'b0, 32'd12, 32'd0);
        for (int i = 0; i < 40; i++) begin
            sz = int'($urandom_range(0, 2));
            n  = 1 << sz;
            a  = int'($urandom_range(0, 32'(SNAP_BYTES - n)));
            cpu_op(1'($urandom_range(0, 1)), 2'(sz), 1'($urandom_range(0, 1)), 32'(a), $urandom);
        end
        cpu_idle();
    endtask

    task automatic test_snapshot_idle();
        int cycles;
        copy_snap_model();
        @(negedge clk);
        snap_start = 1'b1;
        @(negedge clk);
        snap_start = 1'b0;
        checks++;
        if (snap_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL snap_busy_start: got %b, required 1", snap_busy);
        end
        wait_snap_done(cycles);
        checks++;
        if (snap_done !== 1'b1 || cycles != SNAP_ROWS + 1) begin
            errors++;
            $display("[TB] FAIL snap_latency: got done=%b after %0d cycles, required done=1 after %0d",
                     snap_done, cycles, SNAP_ROWS + 1);
        end
        checks++;
        if (snap_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL snap_busy_done: got %b, required 0", snap_busy);
        end
        checks++;
        if (snap_bytes !== pack_snap()) begin
            errors++;
            $display("[TB] FAIL snap_data_idle: got %h, required %h", snap_bytes, pack_snap());
        end
        checks++;
        if (snap_bytes[8*SNAP_BYTES-1 -: 8] !== mem_model[0]) begin
            errors++;
            $display("[TB] FAIL snap_byte0: got %h, required %h", snap_bytes[8*SNAP_BYTES-1 -: 8], mem_model[0]);
        end
        @(negedge clk);
        checks++;
        if (snap_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL snap_done_pulse: got %b, required 0", snap_done);
        end
    endtask

    task automatic test_snapshot_contention();
        int          cycles;
        logic [31:0] newv;
        newv = 32'h9E8D7C6B;
        cpu_op(1'b0, 2'd2, 1'b0, 32'd0, 32'd0);
        snap_start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 10)
                cpu_op(1'b1, 2'd2, 1'b0, 32'd20, newv);
            else
                cpu_op(1'b0, 2'd2, 1'($urandom_range(0, 1)), 32'(4 * $urandom_range(0, 7)), 32'd0);
            snap_start = 1'b0;
            checks++;
            if (req_ready !== 1'b1 || snap_busy !== 1'b1 || snap_done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL snap_contend_%0d: got ready=%b busy=%b done=%b, required 1 1 0",
                         i, req_ready, snap_busy, snap_done);
            end
        end
        cpu_idle();
        copy_snap_model();
        wait_snap_done(cycles);
        checks++;
        if (snap_done !== 1'b1 || cycles != SNAP_ROWS + 1) begin
            errors++;
            $display("[TB] FAIL snap_resume: got done=%b after %0d cycles, required done=1 after %0d",
                     snap_done, cycles, SNAP_ROWS + 1);
        end
        checks++;
        if (snap_bytes !== pack_snap() || snap_bytes[8*(SNAP_BYTES-1-20) +: 8] !== newv[31:24]) begin
            errors++;
            $display("[TB] FAIL snap_data_contend: got %h, required %h", snap_bytes, pack_snap());
        end

        // A store to an already-scanned row must not appear; one to an unscanned row must.
        copy_snap_model();
        @(negedge clk);
        snap_start = 1'b1;
        @(negedge clk);
        snap_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cpu_op(1'b1, 2'd2, 1'b0, 32'd0, 32'h0BADF00D);
        cpu_op(1'b1, 2'd2, 1'b0, 32'd28, 32'h600DCAFE);
        for (int k = 28; k < 32; k++)
            snap_model[k] = mem_model[k];
        cpu_idle();
        wait_snap_done(cycles);
        checks++;
        if (snap_done !== 1'b1 || snap_bytes !== pack_snap()) begin
            errors++;
            $display("[TB] FAIL snap_coherence: got done=%b bytes=%h, required bytes=%h",
                     snap_done, snap_bytes, pack_snap());
        end
    endtask

    task automatic test_reset_mid();
        int cycles;
        @(negedge clk);
        snap_start = 1'b1;
        @(negedge clk);
        snap_start = 1'b0;
        repeat (2) @(negedge clk);
        cpu_op(1'b0, 2'd2, 1'b0, 32'd4, 32'd0);
        @(posedge clk);
        #2;
        resetn    = 1'b0;
        req_valid = 1'b0;
        sb.delete();
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_port: got valid=%b ready=%b, required 0 0", rsp_valid, req_ready);
        end
        checks++;
        if (snap_busy !== 1'b0 || snap_done !== 1'b0 || snap_bytes !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mid_snap: got busy=%b done=%b bytes=%h, required zeros",
                     snap_busy, snap_done, snap_bytes);
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_mid_ready: got %b, required 1", req_ready);
        end
        cpu_op(1'b0, 2'd2, 1'b0, 32'd0, 32'd0);
        cpu_op(1'b0, 2'd2, 1'b0, 32'd28, 32'd0);
        cpu_idle();
        copy_snap_model();
        @(negedge clk);
        snap_start = 1'b1;
        @(negedge clk);
        snap_start = 1'b0;
        wait_snap_done(cycles);
        checks++;
        if (snap_done !== 1'b1 || snap_bytes !== pack_snap()) begin
            errors++;
            $display("[TB] FAIL snap_after_reset: got done=%b bytes=%h, required bytes=%h",
                     snap_done, snap_bytes, pack_snap());
        end
    endtask

    initial begin : watchdog
        #2000000;
        errors++;
        $display("[TB] FAIL watchdog: simulation exceeded its time budget");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        test_reset();
        test_fill();
        test_load_store();
        test_unaligned();
        test_errors();
        test_back_to_back();
        test_snapshot_idle();
        test_snapshot_contention();
        test_reset_mid();
        cpu_idle();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL rsp_missing: got %0d outstanding responses, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
